score_bcd_encoder: RTL and testbench

Upstream feeder for the LCD menu overlay's 5-digit numeric field (slots data1..data5). It accepts a 16-bit binary value from the game/Wishbone logic and converts it to 5 BCD digits with a sequential double-dabble, one iteration per clock. Each digit is encoded to a 14-bit segment mask, and the outputs are committed only on a frame tick so that a digit never changes mid-frame.

---
 rtl/score_bcd_encoder.sv | 182 ++++++++++++++++++
 tb/tb_score_bcd_encoder.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/score_bcd_encoder.sv
// score_bcd_encoder
// Converts a binary score into five 14-bit segment masks for the LCD menu
// overlay's numeric field. A sequential double-dabble runs one iteration
// per clock; the encoded digits are committed only on a frame tick, so the
// visible field never changes mid-frame.
//
// Ports:
//   clk         system clock
//   reset       asynchronous, active-high reset
//   value_in    binary value to display (BIN_W bits)
//   load        one-cycle strobe capturing value_in
//   frame_tick  one-cycle pulse per frame (vertical blank)
//   busy        high while converting or while a result awaits commit
//   updated     one-cycle pulse on the cycle after seg0..seg4 change
//   seg0..seg4  digit masks, seg0 = units (rightmost), seg4 = leftmost
module score_bcd_encoder #(
    parameter int BIN_W    = 16,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [BIN_W-1:0] value_in,
    input  logic             load,
    input  logic             frame_tick,
    output logic             busy,
    output logic             updated,
    output logic [13:0]      seg0,
    output logic [13:0]      seg1,
    output logic [13:0]      seg2,
    output logic [13:0]      seg3,
    output logic [13:0]      seg4
);

    localparam int          CNT_W      = $clog2(BIN_W + 1);
    localparam logic [13:0] SEG_ZERO   = 14'h003F;
    localparam logic [13:0] SEG_HI_RST = BLANK_LZ ? 14'h0000 : SEG_ZERO;

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

    state_t             r_state;
    logic               r_busy;
    logic               r_commit;
    logic               r_updated;
    logic               r_pend;
    logic [BIN_W-1:0]   r_pend_val;
    logic [BIN_W-1:0]   r_bin;
    logic [19:0]        r_bcd;
    logic [CNT_W-1:0]   r_cnt;
    logic [13:0]        r_seg0, r_seg1, r_seg2, r_seg3, r_seg4;

    logic [19:0]        w_adj;
    logic [19+BIN_W:0]  w_shifted;
    logic               w_last;
    logic [4:0]         w_show;
    logic [13:0]        w_enc [5];

    function automatic logic [3:0] add3(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

    function automatic logic [13:0] seg_encode(input logic [3:0] d);
        case (d)
            4'd0:    return 14'h003F;
            4'd1:    return 14'h0006;
            4'd2:    return 14'h005B;
            4'd3:    return 14'h004F;
            4'd4:    return 14'h0066;
            4'd5:    return 14'h006D;
            4'd6:    return 14'h007D;
            4'd7:    return 14'h0007;
            4'd8:    return 14'h007F;
            4'd9:    return 14'h006F;
            default: return 14'h0000;
        endcase
    endfunction

    // One double-dabble iteration: correct every nibble, then shift the
    // combined {bcd, bin} register left by one.
    always_comb begin
        w_adj = '0;
        for (int k = 0; k < 5; k++) begin
            w_adj[4*k +: 4] = add3(r_bcd[4*k +: 4]);
        end
    end

    assign w_shifted = {w_adj, r_bin} << 1;
    assign w_last    = (r_cnt == CNT_W'(BIN_W - 1));

    // A digit is shown when it or any higher digit is nonzero; the units
    // digit is always shown.
    always_comb begin
        w_show = '0;
        for (int k = 0; k < 5; k++) begin
            w_show[k] = ((r_bcd >> (4 * k)) != 20'd0) || (k == 0) || !BLANK_LZ;
            w_enc[k]  = w_show[k] ? seg_encode(r_bcd[4*k +: 4]) : 14'h0000;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_busy     <= 1'b0;
            r_commit   <= 1'b0;
            r_updated  <= 1'b0;
            r_pend     <= 1'b0;
            r_pend_val <= '0;
            r_bin      <= '0;
            r_bcd      <= '0;
            r_cnt      <= '0;
            r_seg0     <= SEG_ZERO;
            r_seg1     <= SEG_HI_RST;
            r_seg2     <= SEG_HI_RST;
            r_seg3     <= SEG_HI_RST;
            r_seg4     <= SEG_HI_RST;
        end else begin
            r_commit  <= 1'b0;
            r_updated <= r_commit;
            case (r_state)
                IDLE: begin
                    if (load) begin
                        r_bin   <= value_in;
                        r_bcd   <= '0;
                        r_cnt   <= '0;
                        r_state <= SHIFT;
                        r_busy  <= 1'b1;
                    end
                end
                SHIFT: begin
                    r_bcd <= w_shifted[19+BIN_W:BIN_W];
                    r_bin <= w_shifted[BIN_W-1:0];
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        // A queued value supersedes the result just finished.
                        if (r_pend || load) begin
                            r_bin  <= load ? value_in : r_pend_val;
                            r_bcd  <= '0;
                            r_cnt  <= '0;
                            r_pend <= 1'b0;
                        end else begin
                            r_state <= HOLD;
                        end
                    end else if (load) begin
                        r_pend     <= 1'b1;
                        r_pend_val <= value_in;
                    end
                end
                HOLD: begin
                    if (frame_tick) begin
                        r_seg0   <= w_enc[0];
                        r_seg1   <= w_enc[1];
                        r_seg2   <= w_enc[2];
                        r_seg3   <= w_enc[3];
                        r_seg4   <= w_enc[4];
                        r_commit <= 1'b1;
                    end
                    if (load) begin
                        r_bin   <= value_in;
                        r_bcd   <= '0;
                        r_cnt   <= '0;
                        r_state <= SHIFT;
                    end else if (frame_tick) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign updated = r_updated;
    assign seg0    = r_seg0;
    assign seg1    = r_seg1;
    assign seg2    = r_seg2;
    assign seg3    = r_seg3;
    assign seg4    = r_seg4;

endmodule

// File: tb/tb_score_bcd_encoder.sv
// Testbench for score_bcd_encoder: two instances (leading-zero blanking on
// and off) share one stimulus stream. Expected displays are queued when the
// committing frame tick is issued; monitors pop and compare on updated.
module tb_score_bcd_encoder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] value_in = '0;
    logic        load = 1'b0;
    logic        frame_tick = 1'b0;

    logic        busy_b, updated_b, busy_z, updated_z;
    logic [13:0] sb [5];
    logic [13:0] sz [5];
    logic [69:0] cur_b, cur_z;

    int checks = 0;
    int errors = 0;
    int n_push = 0;
    int upd_b  = 0;
    int upd_z  = 0;
    logic [69:0] q_b [$];
    logic [69:0] q_z [$];

    localparam logic [69:0] RST_B = {14'h0000, 14'h0000, 14'h0000, 14'h0000, 14'h003F};
    localparam logic [69:0] RST_Z = {14'h003F, 14'h003F, 14'h003F, 14'h003F, 14'h003F};

    always #5 clk = ~clk;

    score_bcd_encoder #(.BIN_W(16), .BLANK_LZ(1'b1)) dut_b (
        .clk(clk), .reset(reset), .value_in(value_in), .load(load),
        .frame_tick(frame_tick), .busy(busy_b), .updated(updated_b),
        .seg0(sb[0]), .seg1(sb[1]), .seg2(sb[2]), .seg3(sb[3]), .seg4(sb[4])
    );

    score_bcd_encoder #(.BIN_W(16), .BLANK_LZ(1'b0)) dut_z (
        .clk(clk), .reset(reset), .value_in(value_in), .load(load),
        .frame_tick(frame_tick), .busy(busy_z), .updated(updated_z),
        .seg0(sz[0]), .seg1(sz[1]), .seg2(sz[2]), .seg3(sz[3]), .seg4(sz[4])
    );

    assign cur_b = {sb[4], sb[3], sb[2], sb[1], sb[0]};
    assign cur_z = {sz[4], sz[3], sz[2], sz[1], sz[0]};

    function automatic logic [13:0] digit_mask(input int d);
        logic [13:0] tab [10];
        tab = '{14'h003F, 14'h0006, 14'h005B, 14'h004F, 14'h0066,
                14'h006D, 14'h007D, 14'h0007, 14'h007F, 14'h006F};
        return tab[d];
    endfunction

    // Decimal digits by division; digit k is blank when v < 10^k.
    function automatic logic [69:0] ref_segs(input int v, input bit blank);
        logic [69:0] r;
        int p;
        r = '0;
        p = 1;
        for (int k = 0; k < 5; k++) begin
            if (blank && k > 0 && v < p) r[14*k +: 14] = 14'h0000;
            else                         r[14*k +: 14] = digit_mask((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_exp(input int v);
        q_b.push_back(ref_segs(v, 1'b1));
        q_z.push_back(ref_segs(v, 1'b0));
        n_push++;
    endtask

    task automatic do_load(input int v);
        value_in = 16'(v);
        load = 1'b1;
        step(1);
        load = 1'b0;
        value_in = 16'($urandom);
    endtask

    task automatic do_tick(input bit push, input int v);
        frame_tick = 1'b1;
        if (push) push_exp(v);
        step(1);
        frame_tick = 1'b0;
    endtask

    always @(negedge clk) begin
        if (updated_b === 1'b1) begin
            upd_b++;
            if (q_b.size() == 0) check("upd_b_expected", 70'(q_b.size() != 0), 70'd1);
            else                 check("segs_b", cur_b, q_b.pop_front());
        end
    end

    always @(negedge clk) begin
        if (updated_z === 1'b1) begin
            upd_z++;
            if (q_z.size() == 0) check("upd_z_expected", 70'(q_z.size() != 0), 70'd1);
            else                 check("segs_z", cur_z, q_z.pop_front());
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int v, fin, off1, off2, mode, ready, tick_at, ub;
        bit ld, spur_ok;

        // Reset and idle
        #2 reset = 1'b1;
        #1;
        check("rst_segs_b", cur_b, RST_B);
        check("rst_segs_z", cur_z, RST_Z);
        check("rst_busy", {busy_b, busy_z, updated_b, updated_z}, 70'd0);
        step(3);
        reset = 1'b0;
        step(1000);
        check("idle_segs_b", cur_b, RST_B);
        check("idle_segs_z", cur_z, RST_Z);
        check("idle_busy", {busy_b, busy_z}, 70'd0);
        check("idle_no_update", 70'(upd_b + upd_z), 70'd0);

        // 12345, tick 40 cycles after load
        do_load(12345);
        check("busy_n0", 70'(busy_b), 70'd1);
        for (int i = 1; i < 40; i++) begin
            step(1);
            check("busy_hold", 70'(busy_b & busy_z), 70'd1);
        end
        ub = upd_b;
        do_tick(1'b1, 12345);
        check("busy_after_commit", {busy_b, busy_z}, 70'd0);
        check("v12345_b", cur_b, {14'h0006, 14'h005B, 14'h004F, 14'h0066, 14'h006D});
        check("v12345_z", cur_z, {14'h0006, 14'h005B, 14'h004F, 14'h0066, 14'h006D});
        step(3);
        check("v12345_one_update", 70'(upd_b - ub), 70'd1);

        // Earliest commit edge: tick at N+16 is ignored, N+17 commits
        v = int'($urandom_range(0, 65535));
        do_load(v);
        step(15);
        do_tick(1'b0, 0);
        do_tick(1'b1, v);
        step(3);

        // 65535 superseded by pending 7
        do_load(65535);
        step(4);
        do_load(7);
        step(11);
        do_tick(1'b0, 0);
        step(14);
        check("pend_busy_31", 70'(busy_b), 70'd1);
        do_tick(1'b0, 0);
        do_tick(1'b1, 7);
        step(3);
        check("pend_v7_b", cur_b, {14'h0000, 14'h0000, 14'h0000, 14'h0000, 14'h0007});

        // 100, tick during SHIFT has no effect
        do_load(100);
        step(7);
        do_tick(1'b0, 0);
        check("shift_tick_nochange", cur_b, {14'h0000, 14'h0000, 14'h0000, 14'h0000, 14'h0007});
        step(11);
        do_tick(1'b1, 100);
        step(3);
        check("v100_z", cur_z, {14'h003F, 14'h003F, 14'h0006, 14'h003F, 14'h003F});
        check("v100_b", cur_b, {14'h0000, 14'h0000, 14'h0006, 14'h003F, 14'h003F});

        // Load and tick together in HOLD
        do_load(500);
        step(19);
        value_in = 16'd42;
        load = 1'b1;
        do_tick(1'b1, 500);
        load = 1'b0;
        check("same_cycle_busy", 70'(busy_b), 70'd1);
        step(19);
        do_tick(1'b1, 42);
        check("v42_busy_low", 70'(busy_b), 70'd0);
        step(3);

        // Load in HOLD without tick discards the held result
        do_load(321);
        step(19);
        do_load(888);
        step(9);
        do_tick(1'b0, 0);
        step(9);
        do_tick(1'b1, 888);
        step(3);

        // Reset mid-conversion
        ub = upd_b + upd_z;
        do_load(9999);
        step(8);
        #2 reset = 1'b1;
        #1;
        check("midrst_segs_b", cur_b, RST_B);
        check("midrst_segs_z", cur_z, RST_Z);
        check("midrst_busy", {busy_b, busy_z}, 70'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        do_tick(1'b0, 0);
        step(20);
        do_tick(1'b0, 0);
        step(3);
        check("midrst_no_update", 70'(upd_b + upd_z - ub), 70'd0);
        check("midrst_segs_after_b", cur_b, RST_B);

        // Randomized transactions
        for (int t = 0; t < 40; t++) begin
            v = int'($urandom_range(0, 65535));
            if ($urandom_range(0, 3) == 0) v = int'($urandom_range(0, 99));
            mode = int'($urandom_range(0, 2));
            off1 = -1;
            off2 = -1;
            fin = v;
            ready = 16;
            if (mode == 1) begin
                off1 = int'($urandom_range(1, 14));
                if ($urandom_range(0, 1) == 1) off2 = int'($urandom_range(off1 + 1, 15));
                ready = 32;
            end else if (mode == 2) begin
                off1 = 16 + int'($urandom_range(1, 3));
                ready = off1 + 16;
            end
            tick_at = ready + 1 + int'($urandom_range(0, 4));
            do_load(v);
            for (int d = 1; d <= tick_at; d++) begin
                ld = (d == off1) || (d == off2);
                if (ld) begin
                    fin = int'($urandom_range(0, 65535));
                    value_in = 16'(fin);
                end else begin
                    value_in = 16'($urandom);
                end
                load = ld;
                if (mode == 2) spur_ok = (d <= 16) || (d > off1 && d <= ready);
                else           spur_ok = (d <= ready);
                frame_tick = (d == tick_at) || (spur_ok && !ld && $urandom_range(0, 7) == 0);
                if (d == tick_at) push_exp(fin);
                step(1);
            end
            load = 1'b0;
            frame_tick = 1'b0;
            check("rand_busy_low", {busy_b, busy_z}, 70'd0);
            step(int'($urandom_range(2, 4)));
        end

        step(5);
        check("queue_b_drained", 70'(q_b.size()), 70'd0);
        check("queue_z_drained", 70'(q_z.size()), 70'd0);
        check("update_count_b", 70'(upd_b), 70'(n_push));
        check("update_count_z", 70'(upd_z), 70'(n_push));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
